// File: rtl/mcu_mbox_pkg.sv
// Shared types and constants for the HPS-to-FPGA PIO mailbox responder.
package mcu_mbox_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned WORD_W = 32;

  localparam int unsigned CMD_TOG_BIT = 31;

  localparam int unsigned CFG_CACHE_LSB = 0;
  localparam int unsigned CFG_CACHE_W   = 4;
  localparam int unsigned CFG_PROT_LSB  = 4;
  localparam int unsigned CFG_PROT_W    = 3;
  localparam int unsigned CFG_USER_LSB  = 7;
  localparam int unsigned CFG_USER_W    = 5;

  localparam logic [ADDR_W-1:0] ADDR_AWCFG = 8'd0;
  localparam logic [ADDR_W-1:0] ADDR_ARCFG = 8'd1;
  localparam logic [ADDR_W-1:0] ADDR_TS_LO = 8'd3;
  localparam logic [ADDR_W-1:0] ADDR_TS_HI = 8'd4;
  localparam logic [ADDR_W-1:0] ADDR_STAT  = 8'd5;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_SET   = 3'd3,
    OP_CLR   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_BADADDR = 3'd1,
    ST_BADOP   = 3'd2,
    ST_RO      = 3'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              tog;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        rsvd;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic              ack;
    status_e           status;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        zero;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  function automatic logic is_ts_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_TS_LO) || (a == ADDR_TS_HI);
  endfunction

endpackage

// File: rtl/mcu_mbox_timestamp.sv
// Free-running 32-bit cycle counter with a HI shadow captured on a TS_LO read.
// Only compiled when MCU_MBOX_TIMESTAMP_EN is defined.
`ifdef MCU_MBOX_TIMESTAMP_EN
module mcu_mbox_timestamp
  import mcu_mbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              snap,
  output logic [DATA_W-1:0] ts_lo_c,
  output logic [DATA_W-1:0] ts_hi_q
);

  logic [TS_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] ts_hi_d;

  // LO and the HI snapshot come from the same counter value, keeping a LO/HI pair coherent
  always_comb begin
    cnt_d   = cnt_q + TS_W'(1);
    ts_hi_d = ts_hi_q;
    if (snap) ts_hi_d = cnt_q[TS_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ts_hi_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ts_hi_q <= ts_hi_d;
    end
  end

  assign ts_lo_c = cnt_q[DATA_W-1:0];

endmodule
`endif

// File: rtl/mcu_axi_mbox_responder.sv
// Fabric-side mailbox responder: toggle-flagged commands against a small register
// file that drives the f2h AXI sideband. MCU_MBOX_TIMESTAMP_EN adds the timestamp regs.
module mcu_axi_mbox_responder
  import mcu_mbox_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_W    = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] cmd_in,
  output logic [31:0] rsp_out,
  output logic [3:0]  axi_signals_awcache,
  output logic [2:0]  axi_signals_awprot,
  output logic [4:0]  axi_signals_awuser,
  output logic [3:0]  axi_signals_arcache,
  output logic [2:0]  axi_signals_arprot,
  output logic [4:0]  axi_signals_aruser
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    cmd_q, cmd_d;
  cmd_t                 cmd_r_q, cmd_r_d;
  rsp_t                 rsp_q, rsp_d;
  status_e              status_q, status_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [REG_W-1:0]     reg_q [NUM_REGS];
  logic [REG_W-1:0]     reg_d [NUM_REGS];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;

  logic [IDX_W-1:0]     idx_c;
  logic                 addr_ok_c;
  logic                 is_ro_c;
  logic [DATA_W-1:0]    cur_val_c;
  logic [DATA_W-1:0]    new_val_c;
  status_e              ex_status_c;
  logic [DATA_W-1:0]    ex_rdata_c;
  logic                 ex_we_c;
  logic                 unused_rsvd;

  assign unused_rsvd = ^cmd_r_q.rsvd;

`ifdef MCU_MBOX_TIMESTAMP_EN
  logic              ts_snap_c;
  logic [DATA_W-1:0] ts_lo_c;
  logic [DATA_W-1:0] ts_hi;

  mcu_mbox_timestamp u_ts (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .snap    (ts_snap_c),
    .ts_lo_c (ts_lo_c),
    .ts_hi_q (ts_hi)
  );
`endif

  // Decode and evaluate the captured command; only consumed while in EXEC
  always_comb begin
    idx_c       = cmd_r_q.addr[IDX_W-1:0];
    is_ro_c     = is_ts_addr(cmd_r_q.addr) || (cmd_r_q.addr == ADDR_STAT);
`ifdef MCU_MBOX_TIMESTAMP_EN
    addr_ok_c   = ({1'b0, cmd_r_q.addr} < NUM_REGS_A);
`else
    addr_ok_c   = ({1'b0, cmd_r_q.addr} < NUM_REGS_A) && !is_ts_addr(cmd_r_q.addr);
`endif
    cur_val_c   = DATA_W'(reg_q[idx_c]);
    new_val_c   = cur_val_c;
    ex_status_c = ST_OK;
    ex_rdata_c  = '0;
    ex_we_c     = 1'b0;

    if (cmd_r_q.addr == ADDR_STAT) cur_val_c = {ovr_q, cnt_q};
`ifdef MCU_MBOX_TIMESTAMP_EN
    ts_snap_c = 1'b0;
    if (cmd_r_q.addr == ADDR_TS_LO) cur_val_c = ts_lo_c;
    if (cmd_r_q.addr == ADDR_TS_HI) cur_val_c = ts_hi;
`endif

    if (!addr_ok_c) begin
      ex_status_c = ST_BADADDR;
    end else begin
      case (op_e'(cmd_r_q.op))
        OP_NOP:  ex_rdata_c = cur_val_c;
        OP_READ: begin
          ex_rdata_c = cur_val_c;
`ifdef MCU_MBOX_TIMESTAMP_EN
          ts_snap_c  = (state_q == S_EXEC) && (cmd_r_q.addr == ADDR_TS_LO);
`endif
        end
        OP_WRITE, OP_SET, OP_CLR: begin
          case (op_e'(cmd_r_q.op))
            OP_WRITE: new_val_c = cmd_r_q.data;
            OP_SET:   new_val_c = cur_val_c | cmd_r_q.data;
            default:  new_val_c = cur_val_c & ~cmd_r_q.data;
          endcase
          if (is_ro_c) begin
            ex_status_c = ST_RO;
            ex_rdata_c  = cur_val_c;
          end else begin
            ex_we_c    = 1'b1;
            ex_rdata_c = new_val_c;
          end
        end
        default: ex_status_c = ST_BADOP;
      endcase
    end
  end

  // Mailbox handshake FSM; STAT reads observe the count before the current command
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_in;
    cmd_r_d  = cmd_r_q;
    rsp_d    = rsp_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_q[CMD_TOG_BIT] != rsp_q.ack) begin
          state_d = S_EXEC;
          cmd_r_d = cmd_t'(cmd_q);
        end
      end
      S_EXEC: begin
        state_d  = S_RESP;
        status_d = ex_status_c;
        rdata_d  = ex_rdata_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (ex_we_c) reg_d[idx_c] = REG_W'(new_val_c);
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_d.ack    = cmd_r_q.tog;
        rsp_d.status = status_q;
        rsp_d.addr   = cmd_r_q.addr;
        rsp_d.zero   = '0;
        rsp_d.rdata  = rdata_q;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_EXEC || state_q == S_RESP) && (cmd_q[CMD_TOG_BIT] != cmd_r_q.tog)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      cmd_r_q  <= '0;
      rsp_q    <= '0;
      status_q <= ST_OK;
      rdata_q  <= '0;
      reg_q    <= '{default: '0};
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmd_r_q  <= cmd_r_d;
      rsp_q    <= rsp_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rsp_out = rsp_q;

  assign axi_signals_awcache = reg_q[IDX_W'(ADDR_AWCFG)][CFG_CACHE_LSB +: CFG_CACHE_W];
  assign axi_signals_awprot  = reg_q[IDX_W'(ADDR_AWCFG)][CFG_PROT_LSB  +: CFG_PROT_W];
  assign axi_signals_awuser  = reg_q[IDX_W'(ADDR_AWCFG)][CFG_USER_LSB  +: CFG_USER_W];
  assign axi_signals_arcache = reg_q[IDX_W'(ADDR_ARCFG)][CFG_CACHE_LSB +: CFG_CACHE_W];
  assign axi_signals_arprot  = reg_q[IDX_W'(ADDR_ARCFG)][CFG_PROT_LSB  +: CFG_PROT_W];
  assign axi_signals_aruser  = reg_q[IDX_W'(ADDR_ARCFG)][CFG_USER_LSB  +: CFG_USER_W];

endmodule

// File: tb/tb_mcu_axi_mbox_responder.sv
// Self-checking bench for mcu_axi_mbox_responder (default and MCU_MBOX_TIMESTAMP_EN builds).
module tb_mcu_axi_mbox_responder;

`ifdef MCU_MBOX_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] cmd_in = '0;
  logic [31:0] rsp_out;
  logic [3:0]  axi_signals_awcache, axi_signals_arcache;
  logic [2:0]  axi_signals_awprot, axi_signals_arprot;
  logic [4:0]  axi_signals_awuser, axi_signals_aruser;

  mcu_axi_mbox_responder dut (
    .clk_clk             (clk_clk),
    .reset_reset         (reset_reset),
    .cmd_in              (cmd_in),
    .rsp_out             (rsp_out),
    .axi_signals_awcache (axi_signals_awcache),
    .axi_signals_awprot  (axi_signals_awprot),
    .axi_signals_awuser  (axi_signals_awuser),
    .axi_signals_arcache (axi_signals_arcache),
    .axi_signals_arprot  (axi_signals_arprot),
    .axi_signals_aruser  (axi_signals_aruser)
  );

  always #5 clk_clk = ~clk_clk;

  // cycles since reset release; the timestamp counter should equal this
  logic [31:0] cyc = '0;
  always @(posedge clk_clk) cyc <= reset_reset ? 32'd0 : cyc + 32'd1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [15:0] m_regs [8];
  logic [14:0] m_cnt;
  logic        m_ovr;
  logic [15:0] m_shadow;
  logic        m_ack;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_cnt = '0; m_ovr = 1'b0; m_shadow = '0; m_ack = 1'b0;
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] cmd, input logic [31:0] ts);
    logic [2:0]  op = cmd[30:28];
    int          a  = int'(cmd[27:20]);
    logic [15:0] d  = cmd[15:0];
    logic [15:0] cur = '0;
    logic [15:0] nv;
    logic [15:0] rd = '0;
    logic [2:0]  st = 3'd0;
    if (a == 5)      cur = {m_ovr, m_cnt};
    else if (a == 3) cur = ts[15:0];
    else if (a == 4) cur = m_shadow;
    else if (a < 8)  cur = m_regs[a];
    if (a >= 8 || ((a == 3 || a == 4) && !TS_EN)) st = 3'd1;
    else if (op > 3'd4) st = 3'd2;
    else if (op <= 3'd1) begin
      rd = cur;
      if (op == 3'd1 && a == 3) m_shadow = ts[31:16];
    end else begin
      nv = (op == 3'd2) ? d : (op == 3'd3) ? (cur | d) : (cur & ~d);
      if (a >= 3 && a <= 5) begin st = 3'd3; rd = cur; end
      else begin m_regs[a] = nv; rd = nv; end
    end
    m_cnt = m_cnt + 15'd1;
    m_ack = cmd[31];
    return {cmd[31], st, cmd[27:20], 4'h0, rd};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] cmd, output logic [31:0] got, output int lat,
                      output logic [31:0] ts);
    bit done = 1'b0;
    got = '0; lat = 0; ts = '0;
    @(negedge clk_clk);
    cmd_in = cmd;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk_clk);
      if (i == 2) ts = cyc;
      if (rsp_out[31] == cmd[31]) begin
        done = 1'b1; lat = i; got = rsp_out;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no ack for cmd %h", cmd);
    end
  endtask

  task automatic send_chk(input string name, input logic [31:0] cmd, output logic [31:0] got);
    int lat;
    logic [31:0] ts;
    send(cmd, got, lat, ts);
    check(name, got, predict(cmd, ts));
  endtask

  task automatic wait_ack(input logic tog, output logic [31:0] got);
    bit done = 1'b0;
    got = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_clk);
      if (rsp_out[31] == tog) begin done = 1'b1; got = rsp_out; end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: ack %0d never seen", tog);
    end
  endtask

  task automatic check_sideband(input string tag);
    check({tag, "_awcache"}, {28'd0, axi_signals_awcache}, {28'd0, m_regs[0][3:0]});
    check({tag, "_awprot"},  {29'd0, axi_signals_awprot},  {29'd0, m_regs[0][6:4]});
    check({tag, "_awuser"},  {27'd0, axi_signals_awuser},  {27'd0, m_regs[0][11:7]});
    check({tag, "_arcache"}, {28'd0, axi_signals_arcache}, {28'd0, m_regs[1][3:0]});
    check({tag, "_arprot"},  {29'd0, axi_signals_arprot},  {29'd0, m_regs[1][6:4]});
    check({tag, "_aruser"},  {27'd0, axi_signals_aruser},  {27'd0, m_regs[1][11:7]});
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] rsp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] got, got2, lo_rsp, cmd;
  logic [31:0] ts;
  logic [14:0] cnt0;
  logic        t;
  int          lat;
  logic [7:0]  ra;

  initial begin
    vecs[0]  = '{32'hA000_0FA5, 32'h8000_0FA5};  // WRITE AWCFG
    vecs[1]  = '{32'h3020_00F0, 32'h0020_00F0};  // SET scratch2
    vecs[2]  = '{32'hC020_0030, 32'h8020_00C0};  // CLR scratch2
    vecs[3]  = '{32'h1090_0000, 32'h1090_0000};  // READ addr 9
    vecs[4]  = '{32'hE020_1234, 32'hA020_0000};  // opcode 6
    vecs[5]  = '{32'h2050_FFFF, 32'h3050_0005};  // WRITE STAT
    vecs[6]  = '{32'h9050_0000, 32'h8050_0006};  // READ STAT
    vecs[7]  = '{32'h0080_0000, 32'h1080_0000};  // NOP addr 8
    vecs[8]  = '{32'h8000_0000, 32'h8000_0FA5};  // NOP AWCFG
    vecs[9]  = '{32'h2010_0ABC, 32'h0010_0ABC};  // WRITE ARCFG
    vecs[10] = '{32'h9FF0_0000, 32'h9FF0_0000};  // READ addr 0xFF
    vecs[11] = '{32'h2040_1234, TS_EN ? 32'h3040_0000 : 32'h1040_0000};  // WRITE TS_HI

    model_reset();
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("reset_rsp", rsp_out, 32'h0);
    check_sideband("reset");

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].cmd, got, lat, ts);
      void'(predict(vecs[i].cmd, ts));
      check($sformatf("vec%0d", i), got, vecs[i].rsp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
    end
    check("tbl_awcache", {28'd0, axi_signals_awcache}, 32'h5);
    check("tbl_awprot",  {29'd0, axi_signals_awprot},  32'h2);
    check("tbl_awuser",  {27'd0, axi_signals_awuser},  32'h1F);
    check("tbl_arcache", {28'd0, axi_signals_arcache}, 32'hC);
    check("tbl_arprot",  {29'd0, axi_signals_arprot},  32'h3);
    check("tbl_aruser",  {27'd0, axi_signals_aruser},  32'h15);

    // timestamp LO/HI pair separated by 100 idle cycles
    send_chk("ts_lo", {~m_ack, 3'd1, 8'd3, 4'd0, 16'd0}, lo_rsp);
    repeat (100) @(negedge clk_clk);
    send_chk("ts_hi", {~m_ack, 3'd1, 8'd4, 4'd0, 16'd0}, got);
    check("ts_lo_status", {29'd0, lo_rsp[30:28]}, TS_EN ? 32'd0 : 32'd1);
    check("ts_hi_status", {29'd0, got[30:28]},    TS_EN ? 32'd0 : 32'd1);
    if (!TS_EN) check("ts_hi_rdata", {16'd0, got[15:0]}, 32'd0);

    // overrun: two more words while the first executes; only the last one runs
    t = m_ack;
    cnt0 = m_cnt;
    @(negedge clk_clk) cmd_in = {~t, 3'd2, 8'd6, 4'd0, 16'h1111};
    @(negedge clk_clk) cmd_in = { t, 3'd2, 8'd7, 4'd0, 16'h2222};
    @(negedge clk_clk) cmd_in = { t, 3'd2, 8'd6, 4'd0, 16'h3333};
    wait_ack(~t, got);
    check("ovr_first", got, {~t, 3'd0, 8'd6, 4'd0, 16'h1111});
    wait_ack(t, got2);
    check("ovr_last", got2, {t, 3'd0, 8'd6, 4'd0, 16'h3333});
    void'(predict({~t, 3'd2, 8'd6, 4'd0, 16'h1111}, 32'd0));
    void'(predict({ t, 3'd2, 8'd6, 4'd0, 16'h3333}, 32'd0));
    m_ovr = 1'b1;
    send_chk("ovr_lost_word", {~m_ack, 3'd1, 8'd7, 4'd0, 16'd0}, got);
    send_chk("ovr_stat", {~m_ack, 3'd1, 8'd5, 4'd0, 16'd0}, got);
    check("ovr_stat_exp", {16'd0, got[15:0]}, {16'd0, 1'b1, 15'(cnt0 + 15'd3)});

    // randomized commands against the reference model
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 11))
        10:      ra = 8'($urandom);
        11:      ra = 8'hFF;
        default: ra = 8'($urandom_range(0, 9));
      endcase
      cmd = {~m_ack, 3'($urandom_range(0, 7)), ra, 4'($urandom), 16'($urandom)};
      send_chk($sformatf("rand%0d", k), cmd, got);
    end
    check_sideband("rand");

    // reset while a WRITE is in EXEC: dropped, then a toggle-1 command after release
    @(negedge clk_clk) cmd_in = {~m_ack, 3'd2, 8'd2, 4'd0, 16'hBEEF};
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b1;
    cmd_in = {1'b1, 3'd2, 8'd1, 4'd0, 16'h0FFF};
    @(posedge clk_clk);
    @(posedge clk_clk);
    @(negedge clk_clk);
    model_reset();
    check("midrst_rsp", rsp_out, 32'h0);
    check_sideband("midrst");
    reset_reset = 1'b0;
    wait_ack(1'b1, got);
    check("post_rst_cmd", got, predict(cmd_in, 32'd0));
    check_sideband("post_rst");
    send_chk("post_rst_scr2", {~m_ack, 3'd1, 8'd2, 4'd0, 16'd0}, got);
    send_chk("post_rst_stat", {~m_ack, 3'd1, 8'd5, 4'd0, 16'd0}, got);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
